// File: rtl/fetch_stage.sv
// Instruction-fetch stage: presents pc_in to a synchronous instruction memory and holds IF/ID.
// Pre-decodes control flow for the pc block, squashes shadow fetches and freezes on halt.
module fetch_stage #(
    parameter int unsigned J_SHADOW  = 2,
    parameter int unsigned BR_SHADOW = 4,
    parameter logic [5:0]  OP_J      = 6'd40,
    parameter logic [5:0]  OP_HALT   = 6'd63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic [31:0] imem_addr,
    output logic        imem_en,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir_out,
    output logic [31:0] pc_if_out,
    output logic        valid_out,
    output logic [1:0]  jon_d,
    output logic [25:0] addr_d,
    output logic        halted,
    output logic [31:0] fetch_cnt,
    output logic [31:0] squash_cnt
);

    localparam int unsigned MAX_SHADOW = (J_SHADOW > BR_SHADOW) ? J_SHADOW : BR_SHADOW;
    localparam int unsigned CW         = (MAX_SHADOW < 2) ? 1 : $clog2(MAX_SHADOW + 1);

    typedef enum logic [1:0] {BOOT, RUN, SHADOW, HALT} state_t;

    state_t          state;
    logic [31:0]     tag;
    logic [CW-1:0]   shadow_cnt;
    logic [5:0]      op;
    logic            is_j;
    logic            is_br;
    logic            is_halt;
    logic [CW-1:0]   shadow_len;

    assign imem_addr = pc_in;
    assign imem_en   = !rst && (state != HALT);

    always_comb begin
        op         = ir_out[31:26];
        is_j       = valid_out && (op == OP_J);
        is_br      = valid_out && (op inside {6'd32, 6'd33, 6'd34, 6'd35, 6'd42});
        is_halt    = valid_out && (op == OP_HALT);
        jon_d      = is_j ? 2'b01 : (is_br ? 2'b10 : 2'b00);
        addr_d     = is_j ? ir_out[25:0] : '0;
        shadow_len = is_j ? CW'(J_SHADOW) : (is_br ? CW'(BR_SHADOW) : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOOT;
            tag        <= '0;
            ir_out     <= '0;
            pc_if_out  <= '0;
            valid_out  <= 1'b0;
            shadow_cnt <= '0;
            halted     <= 1'b0;
            fetch_cnt  <= '0;
            squash_cnt <= '0;
        end else begin
            tag       <= pc_in;
            pc_if_out <= tag;
            ir_out    <= '0;
            valid_out <= 1'b0;
            unique case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (is_halt) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else if (shadow_len != '0) begin
                        // The word landing on this edge is already the first squash.
                        shadow_cnt <= shadow_len;
                        squash_cnt <= squash_cnt + 32'd1;
                        if (shadow_len > CW'(1))
                            state <= SHADOW;
                    end else begin
                        ir_out    <= imem_rdata;
                        valid_out <= 1'b1;
                        fetch_cnt <= fetch_cnt + 32'd1;
                    end
                end
                SHADOW: begin
                    squash_cnt <= squash_cnt + 32'd1;
                    shadow_cnt <= shadow_cnt - CW'(1);
                    if (shadow_cnt <= CW'(2))
                        state <= RUN;
                end
                HALT: begin
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: behavioural pc block and memory around the DUT, with an
// architectural program walk feeding a scoreboard of expected emitted instructions.
module tb_fetch_stage;

    localparam int unsigned J_SH  = 2;
    localparam int unsigned BR_SH = 4;
    localparam logic [5:0]  OPJ   = 6'd40;
    localparam logic [5:0]  OPH   = 6'd63;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in = '0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] ir_out;
    logic [31:0] pc_if_out;
    logic        valid_out;
    logic [1:0]  jon_d;
    logic [25:0] addr_d;
    logic        halted;
    logic [31:0] fetch_cnt;
    logic [31:0] squash_cnt;

    fetch_stage #(
        .J_SHADOW (J_SH),
        .BR_SHADOW(BR_SH),
        .OP_J     (OPJ),
        .OP_HALT  (OPH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pc_in     (pc_in),
        .imem_addr (imem_addr),
        .imem_en   (imem_en),
        .imem_rdata(imem_rdata),
        .ir_out    (ir_out),
        .pc_if_out (pc_if_out),
        .valid_out (valid_out),
        .jon_d     (jon_d),
        .addr_d    (addr_d),
        .halted    (halted),
        .fetch_cnt (fetch_cnt),
        .squash_cnt(squash_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] mem[256];
    bit          br_taken[256];
    logic [31:0] br_target[256];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_fetch;
    logic [31:0] exp_sq;

    // 0 = plain, 1 = jump, 2 = branch/JR, 3 = halt
    function automatic int kind(input logic [31:0] ins);
        logic [5:0] op;
        op = ins[31:26];
        if (op == OPJ) return 1;
        if (op inside {6'd32, 6'd33, 6'd34, 6'd35, 6'd42}) return 2;
        if (op == OPH) return 3;
        return 0;
    endfunction

    function automatic logic [1:0] exp_jon(input logic [31:0] ins);
        case (kind(ins))
            1:       return 2'b01;
            2:       return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] alu_word();
        return {6'($urandom_range(0, 31)), 26'($urandom)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Architectural walk of the program: every instruction on the executed path, in order.
    task automatic build_expect();
        logic [31:0] pc;
        logic [31:0] ins;
        expq.delete();
        exp_fetch = 0;
        exp_sq    = 0;
        pc        = 0;
        for (int s = 0; s < 300; s++) begin
            ins = mem[pc[7:0]];
            expq.push_back('{pc, ins});
            exp_fetch++;
            if (kind(ins) == 3) break;
            case (kind(ins))
                1: begin
                    exp_sq += J_SH;
                    pc = {6'b0, ins[25:0]} >> 2;
                end
                2: begin
                    exp_sq += BR_SH;
                    pc = br_taken[pc[7:0]] ? br_target[pc[7:0]] : pc + 1;
                end
                default: pc = pc + 1;
            endcase
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) begin
            mem[i]       = $urandom;
            br_taken[i]  = 1'($urandom_range(0, 1));
            br_target[i] = 32'(i) + 32'(2 + $urandom_range(0, 5));
        end
    endtask

    // Forward-only control flow, so every walk ends at the halt.
    task automatic gen_random_prog(input int unsigned len);
        logic [31:0] pc;
        logic [31:0] tgt;
        int unsigned r;
        fill_random();
        pc = 0;
        for (int unsigned s = 0; s < len; s++) begin
            r = $urandom_range(0, 99);
            if (s == len - 1) begin
                mem[pc[7:0]] = {OPH, 26'($urandom)};
            end else if (r < 10) begin
                tgt = pc + 32'(2 + $urandom_range(0, 5));
                mem[pc[7:0]] = {OPJ, 26'(tgt << 2)};
                pc = tgt;
            end else if (r < 25) begin
                mem[pc[7:0]] = {($urandom_range(0, 4) == 4) ? 6'd42 : 6'(32 + $urandom_range(0, 3)),
                                26'($urandom)};
                br_taken[pc[7:0]]  = 1'($urandom_range(0, 1));
                br_target[pc[7:0]] = pc + 32'(2 + $urandom_range(0, 5));
                pc = br_taken[pc[7:0]] ? br_target[pc[7:0]] : pc + 1;
            end else begin
                mem[pc[7:0]] = alu_word();
                pc = pc + 1;
            end
        end
    endtask

    // pc block: registered redirect one cycle after J, branch target presented after the shadow.
    initial begin : pc_driver
        logic [31:0] pc;
        logic [31:0] j_tgt;
        logic [31:0] b_tgt;
        logic [31:0] rd;
        bit          j_pend;
        bit          rst_last;
        int unsigned br_cd;
        pc = 0; j_tgt = 0; b_tgt = 0; j_pend = 0; rst_last = 1; br_cd = 0;
        forever begin
            @(negedge clk);
            #1;
            rd = imem_en ? mem[pc_in[7:0]] : imem_rdata;
            if (rst || rst_last) begin
                pc = 0; j_pend = 0; br_cd = 0;
            end else begin
                if (j_pend) begin
                    pc = j_tgt;
                    j_pend = 0;
                end else if (br_cd == 1) begin
                    pc = b_tgt;
                end else begin
                    pc = pc + 1;
                end
                if (br_cd > 0) br_cd--;
                if (jon_d == 2'b01) begin
                    j_pend = 1;
                    j_tgt  = {6'b0, addr_d} >> 2;
                end else if (jon_d == 2'b10) begin
                    br_cd = 3;
                    b_tgt = br_taken[pc_if_out[7:0]] ? br_target[pc_if_out[7:0]] : pc_if_out + 1;
                end
            end
            rst_last   = rst;
            imem_rdata = rd;
            pc_in      = pc;
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (valid_out) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_valid", 32'(valid_out), 32'd0);
                    end else begin
                        e = expq.pop_front();
                        chk("pc_if_out", pc_if_out, e.pc);
                        chk("ir_out", ir_out, e.ir);
                        chk("jon_d", 32'(jon_d), 32'(exp_jon(e.ir)));
                        chk("addr_d", 32'(addr_d), (kind(e.ir) == 1) ? 32'(e.ir[25:0]) : 32'd0);
                    end
                end else begin
                    chk("bubble_ir", ir_out, 32'd0);
                    chk("bubble_jon", 32'(jon_d), 32'd0);
                end
            end
        end
    end

    // Called at a negedge with rst already high for one posedge.
    task automatic reset_release();
        chk("rst_ir", ir_out, 32'd0);
        chk("rst_pc_if", pc_if_out, 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_fetch", fetch_cnt, 32'd0);
        chk("rst_squash", squash_cnt, 32'd0);
        chk("rst_jon", 32'(jon_d), 32'd0);
        chk("rst_imem_en", 32'(imem_en), 32'd0);
        build_expect();
        rst = 1'b0;
        @(negedge clk);
        chk("boot_valid", 32'(valid_out), 32'd0);
        chk("imem_addr", imem_addr, pc_in);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset_release();
    endtask

    task automatic finish_prog();
        int unsigned n;
        n = 0;
        while (!halted && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("halted", 32'(halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("halt_valid", 32'(valid_out), 32'd0);
            chk("halt_imem_en", 32'(imem_en), 32'd0);
            chk("halt_fetch", fetch_cnt, exp_fetch);
        end
        chk("queue_drained", 32'(expq.size()), 32'd0);
        chk("squash_cnt", squash_cnt, exp_sq);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int unsigned n;

        // Straight-line code halting at word 4.
        fill_random();
        for (int i = 0; i < 4; i++) mem[i] = alu_word();
        mem[4] = {OPH, 26'($urandom)};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stream_valid", 32'(valid_out), 32'd1);
        end
        finish_prog();
        chk("halt_fetch_5", fetch_cnt, 32'd5);

        // J at 3 -> word 0x10, taken BEQ -> 0x18, not-taken BNE, J sitting in its shadow.
        fill_random();
        for (int i = 0; i < 3; i++) mem[i] = alu_word();
        mem[3] = {OPJ, 26'h40};
        mem[4] = {OPH, 26'h0};
        mem[8'h10] = {6'd32, 26'($urandom)};
        br_taken[8'h10] = 1'b1;
        br_target[8'h10] = 32'h18;
        mem[8'h18] = {6'd33, 26'($urandom)};
        br_taken[8'h18] = 1'b0;
        mem[8'h19] = alu_word();
        mem[8'h1a] = alu_word();
        mem[8'h1b] = {OPH, 26'($urandom)};
        mem[8'h1c] = {OPJ, 26'h0};
        do_reset();
        finish_prog();

        // Reset while in a branch shadow, then a clean rerun.
        fill_random();
        mem[0] = alu_word();
        mem[1] = alu_word();
        mem[2] = {6'd32, 26'($urandom)};
        br_taken[2] = 1'b1;
        br_target[2] = 32'd8;
        mem[3] = {OPJ, 26'h100};
        mem[8] = alu_word();
        mem[9] = alu_word();
        mem[10] = {OPH, 26'($urandom)};
        do_reset();
        n = 0;
        while (!(valid_out && jon_d == 2'b10) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("br_seen", 32'(jon_d), 32'd2);
        @(negedge clk);
        @(negedge clk);
        chk("squash_mid", squash_cnt, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        reset_release();
        finish_prog();

        // Randomized programs.
        for (int p = 0; p < 8; p++) begin
            gen_random_prog($urandom_range(10, 30));
            do_reset();
            finish_prog();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly downstream of the program counter.
- Issues the word address from the pc block to a synchronous instruction memory and holds the IF/ID pipeline register.
- Pre-decodes control-flow opcodes to drive the pc block's jon_d/addr_d inputs, and squashes wrong-path fetches during jump and branch shadows.
- Detects the halt opcode and freezes the front end.

Parameters:
J_SHADOW, 2, number of fetches squashed after a valid J instruction leaves IF/ID
BR_SHADOW, 4, number of fetches squashed after a valid branch (op 32-35) or JR (op 42)
OP_J, 6'd40, opcode of unconditional jump; target is the byte address in instr[25:0]
OP_HALT, 6'd63, halt opcode

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
pc_in  in  32  word address from pc block (its pc_out)
imem_addr  out  32  word address to instruction memory; equals pc_in (combinational)
imem_en  out  1  read enable; 0 while halted or in reset, else 1
imem_rdata  in  32  data for the address presented in the previous cycle (1-cycle synchronous read)
ir_out  out  32  IF/ID instruction; 32'h0 (NOP) when invalid
pc_if_out  out  32  word address of ir_out
valid_out  out  1  ir_out is a real, non-squashed instruction
jon_d  out  2  to pc block: 2'b01 jump, 2'b10 branch/JR, 2'b00 otherwise
addr_d  out  26  ir_out[25:0] when jon_d==2'b01, else 0
halted  out  1  sticky; set once a halt instruction has been emitted
fetch_cnt  out  32  count of instructions emitted with valid_out=1
squash_cnt  out  32  count of fetches squashed

Behaviour:
- Reset (rst=1 at posedge): state=BOOT; IF/ID cleared, so ir_out=0, pc_if_out=0 and valid_out=0. The shadow counter, halted, fetch_cnt and squash_cnt are all 0.
- Reset mid-operation has the same effect and overrides every other event.
- Pipeline timing: address A is presented in cycle t and rdata arrives in t+1. At the end of t+1, rdata and the tag A are written to IF/ID, so A is visible in t+2.
- A tag register delays pc_in by one cycle to pair each address with its rdata.
- FSM states and transitions:
  - BOOT: one cycle. No valid rdata yet, so the write is a bubble. Then go to RUN.
  - RUN: each incoming word is written valid.
  - SHADOW: incoming words are written with valid=0 and ir=0. squash_cnt increments and the counter decrements. When the counter reaches 1, return to RUN after that write.
  - HALT: imem_en=0; IF/ID is written invalid each cycle; counters are frozen. Only rst leaves this state.
- Pre-decode is combinational from IF/ID and gated by valid_out:
  - op = ir_out[31:26].
  - op==OP_J gives jon_d=01.
  - op in {32, 33, 34, 35, 42} gives jon_d=10.
  - An invalid entry always gives jon_d=00.
- Shadow entry: in a cycle where valid_out=1 and jon_d!=0, the counter loads J_SHADOW (for J) or BR_SHADOW (for branch/JR) and the state becomes SHADOW.
  - The load takes effect for the write at that same posedge, so that write is the first squash.
  - The squash applies whether or not the branch is taken.
- Halt: in a cycle where valid_out=1 and op==OP_HALT, halted is set and the state becomes HALT at the next edge.
  - The halt instruction itself was emitted valid and counted.
- Simultaneous events: a valid halt cannot coincide with jon_d!=0, since the opcodes are disjoint.
- A control-flow op seen while invalid is ignored, so nested shadows cannot occur.
- fetch_cnt increments at each posedge where a valid word is written. Both counters wrap modulo 2^32.

Test Plan:
- Reset then straight-line code at words 0..5 (no control ops): valid_out=0 for the first 2 cycles, then pc_if_out=0,1,2,... on consecutive cycles with valid_out=1. jon_d stays 00.
- J at word 3 with instr[25:0]=26'h40 (pc redirect to word 0x10): when word 3 is in IF/ID, jon_d=01 and addr_d=26'h40. The next 2 entries are invalid. The next valid pc_if_out is 0x10; squash_cnt=2.
- Taken BEQ (op 32) at word 2 targeting word 8: jon_d=10 for one cycle, then 4 invalid entries, then pc_if_out=8 valid; squash_cnt=4.
- Not-taken BNE (op 33) at word 2: still 4 invalid entries, then pc_if_out=3 valid. A J inside the shadow must not drive jon_d.
- Halt (op 63) at word 4: emitted valid, then halted=1 and imem_en=0. valid_out stays 0 for 20 cycles and fetch_cnt freezes at 5. Asserting rst then clears halted and restarts at word 0.
- rst asserted for 1 cycle while in SHADOW with counter=3: next cycle state=BOOT, counters 0, and no residual squashing after BOOT.
